mem_arbiter: RTL and testbench

//   Two-client arbiter between the instruction cache (client 0) and data cache (client 1) and the single

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of two cache clients onto one memory port
//
// Purpose: grants one transaction at a time from client 0 (icache) or client 1
// (dcache) to the memory port, with round-robin priority and one bubble cycle
// for arbitration. Read-response beats go only to the client that issued the read.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cN_req_valid/ready/addr/rw      client N address channel (N = 0, 1)
//   cN_req_data_valid/ready/bits/mask  client N write-data channel
//   cN_resp_valid/data              client N read-response channel
//   mem_req_*                       memory address and write-data channels
//   mem_resp_valid/data             memory read-response channel
//   resp_orphan                     sticky flag: response beat with no read outstanding

module mem_arbiter #(
   parameter int ADDR_BITS  = 26,
   parameter int DATA_BITS  = 128,
   parameter int READ_BEATS = 4
) (
   input  logic                   clk,
   input  logic                   reset,

   input  logic                   c0_req_valid,
   output logic                   c0_req_ready,
   input  logic [ADDR_BITS-1:0]   c0_req_addr,
   input  logic                   c0_req_rw,
   input  logic                   c0_req_data_valid,
   output logic                   c0_req_data_ready,
   input  logic [DATA_BITS-1:0]   c0_req_data_bits,
   input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
   output logic                   c0_resp_valid,
   output logic [DATA_BITS-1:0]   c0_resp_data,

   input  logic                   c1_req_valid,
   output logic                   c1_req_ready,
   input  logic [ADDR_BITS-1:0]   c1_req_addr,
   input  logic                   c1_req_rw,
   input  logic                   c1_req_data_valid,
   output logic                   c1_req_data_ready,
   input  logic [DATA_BITS-1:0]   c1_req_data_bits,
   input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
   output logic                   c1_resp_valid,
   output logic [DATA_BITS-1:0]   c1_resp_data,

   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_valid,
   input  logic [DATA_BITS-1:0]   mem_resp_data,

   output logic                   resp_orphan
);

   localparam int CNT_BITS = $clog2(READ_BEATS) + 1;
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(READ_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR      = 2'd1,
      READ_RESP = 2'd2
   } state_t;

   state_t              state;
   logic                grant;
   logic                last_grant;
   logic                addr_done;
   logic                data_done;
   logic [CNT_BITS-1:0] beat_cnt;

   logic                   in_addr;
   logic                   in_resp;
   logic                   g_valid;
   logic                   g_rw;
   logic                   g_data_valid;
   logic [ADDR_BITS-1:0]   g_addr;
   logic [DATA_BITS-1:0]   g_bits;
   logic [DATA_BITS/8-1:0] g_mask;
   logic                   addr_rdy;
   logic                   data_rdy;
   logic                   addr_hs;
   logic                   data_hs;

   assign in_addr = (state == ADDR);
   assign in_resp = (state == READ_RESP);

   // Request fields of whichever client currently holds the grant
   assign g_valid      = grant ? c1_req_valid      : c0_req_valid;
   assign g_rw         = grant ? c1_req_rw         : c0_req_rw;
   assign g_data_valid = grant ? c1_req_data_valid : c0_req_data_valid;
   assign g_addr       = grant ? c1_req_addr       : c0_req_addr;
   assign g_bits       = grant ? c1_req_data_bits  : c0_req_data_bits;
   assign g_mask       = grant ? c1_req_data_mask  : c0_req_data_mask;

   // Memory side: pass-through only while in ADDR; each channel goes quiet once
   // its handshake has completed, and the data channel never runs for reads.
   assign mem_req_valid      = in_addr && g_valid && !addr_done;
   assign mem_req_addr       = in_addr ? g_addr : '0;
   assign mem_req_rw         = in_addr && g_rw;
   assign mem_req_data_valid = in_addr && g_rw && g_data_valid && !data_done;
   assign mem_req_data_bits  = in_addr ? g_bits : '0;
   assign mem_req_data_mask  = in_addr ? g_mask : '0;

   assign addr_rdy = in_addr && !addr_done && mem_req_ready;
   assign data_rdy = in_addr && g_rw && !data_done && mem_req_data_ready;

   assign c0_req_ready      = addr_rdy && !grant;
   assign c1_req_ready      = addr_rdy &&  grant;
   assign c0_req_data_ready = data_rdy && !grant;
   assign c1_req_data_ready = data_rdy &&  grant;

   assign addr_hs = mem_req_valid && mem_req_ready;
   assign data_hs = mem_req_data_valid && mem_req_data_ready;

   // Response beats are forwarded with zero latency, only to the read owner
   assign c0_resp_valid = in_resp && mem_resp_valid && !grant;
   assign c1_resp_valid = in_resp && mem_resp_valid &&  grant;
   assign c0_resp_data  = (in_resp && !grant) ? mem_resp_data : '0;
   assign c1_resp_data  = (in_resp &&  grant) ? mem_resp_data : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         addr_done   <= 1'b0;
         data_done   <= 1'b0;
         beat_cnt    <= '0;
         resp_orphan <= 1'b0;
      end else begin
         // Any beat outside READ_RESP has no owner: drop it and remember that it happened
         if (mem_resp_valid && !in_resp) begin
            resp_orphan <= 1'b1;
         end

         case (state)
            IDLE: begin
               addr_done <= 1'b0;
               data_done <= 1'b0;
               if (c0_req_valid || c1_req_valid) begin
                  // On a tie the client that did not complete last time wins
                  grant <= (c0_req_valid && c1_req_valid) ? ~last_grant : c1_req_valid;
                  state <= ADDR;
               end
            end

            ADDR: begin
               if (!g_rw) begin
                  if (addr_hs) begin
                     beat_cnt <= '0;
                     state    <= READ_RESP;
                  end else if (!g_valid) begin
                     state <= IDLE;
                  end
               end else begin
                  if ((addr_done || addr_hs) && (data_done || data_hs)) begin
                     state      <= IDLE;
                     last_grant <= grant;
                     addr_done  <= 1'b0;
                     data_done  <= 1'b0;
                  end else if (!g_valid && !addr_done && !data_done && !data_hs) begin
                     // Abandoned before any handshake: priority is not rotated
                     state <= IDLE;
                  end else begin
                     if (addr_hs) addr_done <= 1'b1;
                     if (data_hs) data_done <= 1'b1;
                  end
               end
            end

            READ_RESP: begin
               if (mem_resp_valid) begin
                  beat_cnt <= beat_cnt + CNT_BITS'(1);
                  if (beat_cnt == LAST_BEAT) begin
                     state      <= IDLE;
                     last_grant <= grant;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table and sequence checks for mem_arbiter

module tb_mem_arbiter;

   logic          clk;
   logic          reset;
   logic          c0_req_valid, c0_req_ready, c0_req_rw;
   logic [25:0]   c0_req_addr;
   logic          c0_req_data_valid, c0_req_data_ready;
   logic [127:0]  c0_req_data_bits;
   logic [15:0]   c0_req_data_mask;
   logic          c0_resp_valid;
   logic [127:0]  c0_resp_data;
   logic          c1_req_valid, c1_req_ready, c1_req_rw;
   logic [25:0]   c1_req_addr;
   logic          c1_req_data_valid, c1_req_data_ready;
   logic [127:0]  c1_req_data_bits;
   logic [15:0]   c1_req_data_mask;
   logic          c1_resp_valid;
   logic [127:0]  c1_resp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_rw;
   logic [25:0]   mem_req_addr;
   logic          mem_req_data_valid, mem_req_data_ready;
   logic [127:0]  mem_req_data_bits;
   logic [15:0]   mem_req_data_mask;
   logic          mem_resp_valid;
   logic [127:0]  mem_resp_data;
   logic          resp_orphan;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready),
      .c0_req_addr(c0_req_addr), .c0_req_rw(c0_req_rw),
      .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
      .c0_req_data_bits(c0_req_data_bits), .c0_req_data_mask(c0_req_data_mask),
      .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data),
      .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
      .c1_req_addr(c1_req_addr), .c1_req_rw(c1_req_rw),
      .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
      .c1_req_data_bits(c1_req_data_bits), .c1_req_data_mask(c1_req_data_mask),
      .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .resp_orphan(resp_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        c0v;
      logic [25:0] c0a;
      logic        c1v;
      logic [25:0] c1a;
      logic        mrr;
      logic        mrv;
      logic [31:0] d;
      logic [35:0] exp;
   } vec_t;

   vec_t tbl[$];

   // Read-only vectors: rw, data-channel valid and data_ready stay 0
   function automatic vec_t v(input logic rst, input logic c0v, input logic [25:0] c0a,
                              input logic c1v, input logic [25:0] c1a,
                              input logic mrr, input logic mrv, input logic [31:0] d,
                              input logic mv, input logic [25:0] ma, input logic c0r,
                              input logic c1r, input logic c0rv, input logic c1rv,
                              input logic orph);
      vec_t t;
      t.rst = rst; t.c0v = c0v; t.c0a = c0a; t.c1v = c1v; t.c1a = c1a;
      t.mrr = mrr; t.mrv = mrv; t.d = d;
      t.exp = {mv, ma, 1'b0, 1'b0, c0r, c1r, 1'b0, 1'b0, c0rv, c1rv, orph};
      return t;
   endfunction

   function automatic logic [35:0] get_out();
      return {mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid,
              c0_req_ready, c1_req_ready, c0_req_data_ready, c1_req_data_ready,
              c0_resp_valid, c1_resp_valid, resp_orphan};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   localparam logic [25:0] A1 = 26'h10;
   localparam logic [25:0] P  = 26'h100;
   localparam logic [25:0] Q  = 26'h200;

   initial begin
      int addr_acc;
      int data_acc;
      logic [4:0] pat;
      logic [127:0] wdata;

      wdata = {4{32'hC1DA7A00}};
      reset = 1'b1;
      c0_req_valid = 0; c0_req_addr = '0; c0_req_rw = 0; c0_req_data_valid = 0;
      c0_req_data_bits = {4{32'hC0C0C0C0}}; c0_req_data_mask = 16'hFFFF;
      c1_req_valid = 0; c1_req_addr = '0; c1_req_rw = 0; c1_req_data_valid = 0;
      c1_req_data_bits = wdata; c1_req_data_mask = 16'h0F0F;
      mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;

      // Scenario 1: c0 read, four consecutive beats
      tbl.push_back(v(0,1,A1,0,0, 1,0,0,            0,0, 0,0,0,0,0));
      tbl.push_back(v(0,1,A1,0,0, 1,0,0,            1,A1,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0,  1,1,32'hD0000000, 0,0, 0,0,1,0,0));
      tbl.push_back(v(0,0,0,0,0,  1,1,32'hD0000001, 0,0, 0,0,1,0,0));
      tbl.push_back(v(0,0,0,0,0,  1,1,32'hD0000002, 0,0, 0,0,1,0,0));
      tbl.push_back(v(0,0,0,0,0,  1,1,32'hD0000003, 0,0, 0,0,1,0,0));
      tbl.push_back(v(0,0,0,0,0,  0,0,0,            0,0, 0,0,0,0,0));
      tbl.push_back(v(1,0,0,0,0,  0,0,0,            0,0, 0,0,0,0,0));
      // Scenario 2: simultaneous continuous requests -> c0, c1, c0
      tbl.push_back(v(0,1,P,1,Q, 1,0,0,             0,0,0,0,0,0,0));
      tbl.push_back(v(0,1,P,1,Q, 1,0,0,             1,P,1,0,0,0,0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(v(0,1,P,1,Q, 1,1,32'hB0000000 + k, 0,0,0,0,1,0,0));
      tbl.push_back(v(0,1,P,1,Q, 1,0,0,             0,0,0,0,0,0,0));
      tbl.push_back(v(0,1,P,1,Q, 1,0,0,             1,Q,0,1,0,0,0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(v(0,1,P,1,Q, 1,1,32'hB1000000 + k, 0,0,0,0,0,1,0));
      tbl.push_back(v(0,1,P,1,Q, 1,0,0,             0,0,0,0,0,0,0));
      tbl.push_back(v(0,1,P,1,Q, 1,0,0,             1,P,1,0,0,0,0));
      // Scenario 6 / 5: reset after two beats, later beats are orphans
      tbl.push_back(v(0,0,0,0,0, 0,1,32'hE0000000,  0,0,0,0,1,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,1,32'hE0000001,  0,0,0,0,1,0,0));
      tbl.push_back(v(1,0,0,0,0, 0,0,0,             0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,1,32'hE0000002,  0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0, 0,1,32'hE0000003,  0,0,0,0,0,0,1));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,             0,0,0,0,0,0,1));

      // Reset state
      @(negedge clk); #1;
      chk("reset_outputs", 128'(get_out()), 128'd0);
      chk("reset_wide_zero", 128'(|{mem_req_data_bits, mem_req_data_mask, c0_resp_data, c1_resp_data}), 128'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         reset = tbl[i].rst;
         c0_req_valid = tbl[i].c0v; c0_req_addr = tbl[i].c0a; c0_req_rw = 0;
         c1_req_valid = tbl[i].c1v; c1_req_addr = tbl[i].c1a; c1_req_rw = 0;
         c0_req_data_valid = 0; c1_req_data_valid = 0; mem_req_data_ready = 0;
         mem_req_ready = tbl[i].mrr; mem_resp_valid = tbl[i].mrv;
         mem_resp_data = {4{tbl[i].d}};
         #1;
         chk($sformatf("vec%0d", i), 128'(get_out()), 128'(tbl[i].exp));
         if (tbl[i].exp[2]) chk($sformatf("vec%0d_c0_data", i), c0_resp_data, {4{tbl[i].d}});
         if (tbl[i].exp[1]) chk($sformatf("vec%0d_c1_data", i), c1_resp_data, {4{tbl[i].d}});
      end

      // Scenario 3: c1 write, data accepted first, address after 3 stalled cycles
      @(negedge clk);
      mem_resp_valid = 0;
      c1_req_valid = 1; c1_req_rw = 1; c1_req_addr = 26'h3FF; c1_req_data_valid = 1;
      mem_req_data_ready = 1; mem_req_ready = 0;
      #1;
      chk("s3_idle_mv", mem_req_valid, 0);
      chk("s3_idle_c1dr", c1_req_data_ready, 0);
      addr_acc = 0; data_acc = 0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         mem_req_ready = (cyc == 4);
         #1;
         if (mem_req_valid && mem_req_ready && c1_req_ready) addr_acc++;
         if (mem_req_data_valid && mem_req_data_ready && c1_req_data_ready) data_acc++;
         chk($sformatf("s3_c%0d_mv", cyc), mem_req_valid, 1);
         chk($sformatf("s3_c%0d_addr", cyc), mem_req_addr, 26'h3FF);
         chk($sformatf("s3_c%0d_rw", cyc), mem_req_rw, 1);
         chk($sformatf("s3_c%0d_mdv", cyc), mem_req_data_valid, 128'(cyc == 1));
         chk($sformatf("s3_c%0d_c1dr", cyc), c1_req_data_ready, 128'(cyc == 1));
         chk($sformatf("s3_c%0d_c1r", cyc), c1_req_ready, 128'(cyc == 4));
         chk($sformatf("s3_c%0d_c0rdy", cyc), {c0_req_ready, c0_req_data_ready}, 0);
         if (cyc == 1) begin
            chk("s3_wdata", mem_req_data_bits, wdata);
            chk("s3_wmask", mem_req_data_mask, 16'h0F0F);
         end
      end
      @(negedge clk);
      c1_req_valid = 0; c1_req_data_valid = 0; c1_req_rw = 0;
      mem_req_ready = 0; mem_req_data_ready = 0;
      #1;
      chk("s3_back_idle", {mem_req_valid, c1_req_ready, c1_req_data_ready}, 0);
      chk("s3_addr_accepts", addr_acc, 1);
      chk("s3_data_accepts", data_acc, 1);
      chk("s5_orphan_sticky", resp_orphan, 1);

      // Reset clears the sticky orphan flag
      @(negedge clk); reset = 1;
      @(negedge clk); reset = 0; #1;
      chk("orphan_cleared", 128'(get_out()), 128'd0);

      // Scenario 4: c0 read stalled 5 cycles while c1 also requests
      @(negedge clk);
      c0_req_valid = 1; c0_req_rw = 0; c0_req_addr = 26'h4444;
      c1_req_valid = 1; c1_req_rw = 0; c1_req_addr = 26'h222;
      mem_req_ready = 0;
      #1;
      chk("s4_idle_mv", mem_req_valid, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk($sformatf("s4_stall%0d", k), {mem_req_valid, mem_req_addr, c0_req_ready, c1_req_ready},
             {1'b1, 26'h4444, 1'b0, 1'b0});
      end
      @(negedge clk); mem_req_ready = 1; #1;
      chk("s4_accept", {mem_req_valid, mem_req_addr, c0_req_ready, c1_req_ready},
          {1'b1, 26'h4444, 1'b1, 1'b0});
      // Beats with a gap in the middle
      pat = 5'b11101;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         c0_req_valid = 0; mem_req_ready = 0;
         mem_resp_valid = pat[j]; mem_resp_data = {4{32'hF0000000 + j}};
         #1;
         chk($sformatf("s4_beat%0d", j), {mem_req_valid, c0_resp_valid, c1_resp_valid, c1_req_ready},
             {1'b0, pat[j], 1'b0, 1'b0});
         if (pat[j]) chk($sformatf("s4_beat%0d_data", j), c0_resp_data, {4{32'hF0000000 + j}});
      end
      @(negedge clk); mem_resp_valid = 0; #1;
      chk("s4_done_idle", mem_req_valid, 0);
      @(negedge clk); #1;
      chk("s4_c1_granted", {mem_req_valid, mem_req_addr}, {1'b1, 26'h222});

      // Abandon: c1 drops before handshake, priority must not rotate
      @(negedge clk); c1_req_valid = 0; #1;
      chk("abandon_mv", mem_req_valid, 0);
      @(negedge clk); c0_req_valid = 1; c1_req_valid = 1; #1;
      chk("abandon_idle", mem_req_valid, 0);
      @(negedge clk); #1;
      chk("abandon_keeps_last_grant", {mem_req_valid, mem_req_addr, c0_req_ready}, {1'b1, 26'h222, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
